sm83_alu_nibble_seq: RTL

Nibble-serial ALU datapath sequencer for the SM83 core. It processes one 8-bit operation as two 4-bit passes (low nibble, then high nibble), following the Z80 4-bit ALU scheme. It sits directly upstream of the flags unit and produces that unit's zero, carry, shift-out, DAA-carry and sign inputs. The nibble carry is presented twice: at low-nibble completion it is the half carry, at high-nibble completion it is the full carry. Each presentation has a strobe, so the flags unit can write H and C from the same carry line.

---
 rtl/sm83_alu_pkg.sv | 23 ++
 rtl/sm83_alu_nibble.sv | 31 +++
 rtl/sm83_alu_nibble_seq.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/sm83_alu_pkg.sv
// Shared types and constants for the SM83 nibble-serial ALU.
// Holds op codes, sequencer states, nibble-slice functions and DAA adjust constants.
package sm83_alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_AND, OP_XOR, OP_OR, OP_CP,
    OP_INC, OP_DEC, OP_DAA, OP_RLC, OP_RRC, OP_RL, OP_RR, OP_SLA,
    OP_SRA, OP_SRL, OP_SWAP
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE, ST_LO, ST_HI, ST_DONE
  } alu_state_t;

  typedef enum logic [1:0] {
    NF_ARITH, NF_AND, NF_XOR, NF_OR
  } nib_fn_t;

  localparam logic [7:0] DAA_LO_ADJ   = 8'h06;
  localparam logic [7:0] DAA_HI_ADJ   = 8'h60;
  localparam logic [7:0] DAA_HI_LIMIT = 8'h99;

endpackage

// File: rtl/sm83_alu_nibble.sv
// Combinational 4-bit add/subtract/logic slice; time-shared by both nibble passes.
// In subtract mode cin and cout carry borrow sense, so the chained borrow needs no fix-up.
module sm83_alu_nibble
  import sm83_alu_pkg::*;
(
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  input  logic       sub,
  input  nib_fn_t    logic_op,
  output logic [3:0] r,
  output logic       cout
);

  logic [3:0] y_eff;
  logic [4:0] sum;

  always_comb begin
    y_eff = sub ? ~y : y;
    sum   = {1'b0, x} + {1'b0, y_eff} + {4'd0, cin ^ sub};
    r     = sum[3:0];
    cout  = sum[4] ^ sub;
    case (logic_op)
      NF_AND:  begin r = x & y; cout = 1'b0; end
      NF_XOR:  begin r = x ^ y; cout = 1'b0; end
      NF_OR:   begin r = x | y; cout = 1'b0; end
      default: ;
    endcase
  end

endmodule

// File: rtl/sm83_alu_nibble_seq.sv
// Nibble-serial SM83 ALU: start at edge N, half carry strobed after N+1, full result after N+2.
// start is honoured only while ready (IDLE/DONE); requests during LO/HI are silently dropped.
module sm83_alu_nibble_seq
  import sm83_alu_pkg::*;
#(
  parameter int OP_W   = 5,
  parameter bit DAA_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [OP_W-1:0] op,
  input  logic [7:0]      a,
  input  logic [7:0]      b,
  input  logic            c_in,
  input  logic            h_in,
  input  logic            n_in,
  output logic            ready,
  output logic            hc_valid,
  output logic            c_valid,
  output logic            carry_out,
  output logic [7:0]      result,
  output logic            zero_out,
  output logic            sign_out,
  output logic            shift_out,
  output logic            daa_carry
);

  alu_state_t state_q;
  alu_op_t    op_q;
  logic [7:0] a_q, b_q, result_q;
  logic [3:0] lo_q;
  logic       c_q, h_q, n_q, carry_q, zero_q, sign_q, shift_q, daac_q;

  logic [7:0] y8, daa_corr, sh_res, res_d;
  logic       sub, cin0, is_shift, sh_out, lo_fix, hi_fix, daac_d, in_hi;
  nib_fn_t    fn;
  logic [3:0] nib_x, nib_y, nib_r;
  logic       nib_cin, nib_cout;

  // DAA correction depends only on latched operands, so it is stable across both passes.
  always_comb begin
    lo_fix   = n_q ? h_q : (h_q || (a_q[3:0] > 4'd9));
    hi_fix   = n_q ? c_q : (c_q || (a_q > DAA_HI_LIMIT));
    daa_corr = (lo_fix ? DAA_LO_ADJ : 8'h00) | (hi_fix ? DAA_HI_ADJ : 8'h00);
    daac_d   = DAA_EN && (op_q == OP_DAA) && hi_fix;
  end

  always_comb begin
    y8       = b_q;
    sub      = 1'b0;
    cin0     = 1'b0;
    fn       = NF_ARITH;
    is_shift = 1'b0;
    case (op_q)
      OP_ADC:         cin0 = c_q;
      OP_SUB, OP_CP:  sub = 1'b1;
      OP_SBC:         begin sub = 1'b1; cin0 = c_q; end
      OP_AND:         fn = NF_AND;
      OP_XOR:         fn = NF_XOR;
      OP_OR:          fn = NF_OR;
      OP_INC:         y8 = 8'h01;
      OP_DEC:         begin y8 = 8'h01; sub = 1'b1; end
      OP_DAA: begin
        y8  = DAA_EN ? daa_corr : 8'h00;
        sub = DAA_EN && n_q;
      end
      OP_RLC, OP_RRC, OP_RL, OP_RR, OP_SLA, OP_SRA, OP_SRL, OP_SWAP: is_shift = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    sh_res = a_q;
    sh_out = 1'b0;
    case (op_q)
      OP_RLC:  begin sh_res = {a_q[6:0], a_q[7]}; sh_out = a_q[7]; end
      OP_RRC:  begin sh_res = {a_q[0], a_q[7:1]}; sh_out = a_q[0]; end
      OP_RL:   begin sh_res = {a_q[6:0], c_q};    sh_out = a_q[7]; end
      OP_RR:   begin sh_res = {c_q, a_q[7:1]};    sh_out = a_q[0]; end
      OP_SLA:  begin sh_res = {a_q[6:0], 1'b0};   sh_out = a_q[7]; end
      OP_SRA:  begin sh_res = {a_q[7], a_q[7:1]}; sh_out = a_q[0]; end
      OP_SRL:  begin sh_res = {1'b0, a_q[7:1]};   sh_out = a_q[0]; end
      OP_SWAP: sh_res = {a_q[3:0], a_q[7:4]};
      default: ;
    endcase
  end

  assign in_hi   = (state_q == ST_HI);
  assign nib_x   = in_hi ? a_q[7:4] : a_q[3:0];
  assign nib_y   = in_hi ? y8[7:4]  : y8[3:0];
  assign nib_cin = in_hi ? carry_q  : cin0;
  assign res_d   = is_shift ? sh_res : {nib_r, lo_q};

  sm83_alu_nibble u_nibble (
    .x        (nib_x),
    .y        (nib_y),
    .cin      (nib_cin),
    .sub      (sub),
    .logic_op (fn),
    .r        (nib_r),
    .cout     (nib_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_ADD;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      c_q      <= 1'b0;
      h_q      <= 1'b0;
      n_q      <= 1'b0;
      lo_q     <= 4'h0;
      carry_q  <= 1'b0;
      result_q <= 8'h00;
      zero_q   <= 1'b0;
      sign_q   <= 1'b0;
      shift_q  <= 1'b0;
      daac_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q <= ST_LO;
            op_q    <= alu_op_t'(op);
            a_q     <= a;
            b_q     <= b;
            c_q     <= c_in;
            h_q     <= h_in;
            n_q     <= n_in;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_LO: begin
          state_q <= ST_HI;
          lo_q    <= nib_r;
          carry_q <= nib_cout && !is_shift;
        end
        ST_HI: begin
          state_q  <= ST_DONE;
          carry_q  <= nib_cout && !is_shift;
          result_q <= res_d;
          zero_q   <= (res_d == 8'h00);
          sign_q   <= res_d[7];
          shift_q  <= is_shift && sh_out;
          daac_q   <= daac_d;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ready     = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign hc_valid  = (state_q == ST_HI);
  assign c_valid   = (state_q == ST_DONE);
  assign carry_out = carry_q;
  assign result    = result_q;
  assign zero_out  = zero_q;
  assign sign_out  = sign_q;
  assign shift_out = shift_q;
  assign daa_carry = daac_q;

endmodule
